// File: rtl/hall_conditioner.sv
// Hall sensor front end: synchronise, debounce and validate the hall code, check
// commutation order, detect stall and measure the commutation period.
module hall_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STALL_CYCLES    = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       hall_raw,
    input  logic             enable,
    input  logic             clear_fault,
    output logic [2:0]       hall_signal,
    output logic             hall_valid,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam logic [7:0]       DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    function automatic logic is_legal(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    // Forward commutation successor; illegal codes have none.
    function automatic logic [2:0] fwd(input logic [2:0] c);
        case (c)
            3'b001:  return 3'b011;
            3'b011:  return 3'b010;
            3'b010:  return 3'b110;
            3'b110:  return 3'b100;
            3'b100:  return 3'b101;
            3'b101:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    logic [2:0]       sync1, sync2, cand, stable, stable_prev;
    logic [7:0]       dcnt;
    logic [CNT_W-1:0] pcnt;
    logic             armed;

    logic [2:0]       cand_d, stable_d, hall_signal_d;
    logic [7:0]       dcnt_d;
    logic [CNT_W-1:0] pcnt_d, period_d;
    logic             armed_d, fault_d, hall_valid_d, period_valid_d;
    logic [1:0]       fault_code_d, new_code;
    logic             stepped, adjacent, legal_tr, skip, invalid, stall, raise, clearing;

    always_comb begin
        cand_d         = cand;
        stable_d       = stable;
        dcnt_d         = dcnt;
        pcnt_d         = pcnt;
        armed_d        = armed;
        fault_d        = fault;
        fault_code_d   = fault_code;
        period_d       = period;
        period_valid_d = 1'b0;

        if (sync2 != cand) begin
            cand_d = sync2;
            dcnt_d = '0;
        end else if (cand != stable) begin
            if (dcnt == DB_LAST) begin
                stable_d = cand;
                dcnt_d   = '0;
            end else begin
                dcnt_d = dcnt + 8'd1;
            end
        end

        // A stable change is judged on the cycle after it lands in stable.
        stepped  = (stable != stable_prev) && is_legal(stable) && is_legal(stable_prev);
        adjacent = (fwd(stable_prev) == stable) || (fwd(stable) == stable_prev);
        legal_tr = stepped && adjacent;
        skip     = stepped && !adjacent;
        invalid  = !is_legal(stable);
        stall    = (pcnt == STALL_LAST);
        raise    = enable && (invalid || skip || stall);
        new_code = invalid ? 2'b01 : (skip ? 2'b10 : 2'b11);
        clearing = fault && clear_fault && is_legal(stable) && !raise;

        if (raise && (!fault || (clear_fault && is_legal(stable)))) begin
            fault_d      = 1'b1;
            fault_code_d = new_code;
        end else if (clearing) begin
            fault_d      = 1'b0;
            fault_code_d = 2'b00;
        end

        if (!enable || clearing) begin
            pcnt_d  = '0;
            armed_d = 1'b0;
        end else if (legal_tr) begin
            if (armed) begin
                period_d       = (pcnt == CNT_MAX) ? CNT_MAX : pcnt + CNT_W'(1);
                period_valid_d = 1'b1;
            end
            pcnt_d  = '0;
            armed_d = 1'b1;
        end else if (pcnt != CNT_MAX) begin
            pcnt_d = pcnt + CNT_W'(1);
        end

        hall_valid_d  = !fault_d && is_legal(stable_d);
        hall_signal_d = hall_valid_d ? stable_d : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            cand         <= '0;
            stable       <= '0;
            stable_prev  <= '0;
            dcnt         <= '0;
            pcnt         <= '0;
            armed        <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= '0;
            hall_signal  <= '0;
            hall_valid   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            sync1        <= hall_raw;
            sync2        <= sync1;
            cand         <= cand_d;
            stable       <= stable_d;
            stable_prev  <= stable;
            dcnt         <= dcnt_d;
            pcnt         <= pcnt_d;
            armed        <= armed_d;
            fault        <= fault_d;
            fault_code   <= fault_code_d;
            hall_signal  <= hall_signal_d;
            hall_valid   <= hall_valid_d;
            period       <= period_d;
            period_valid <= period_valid_d;
        end
    end

endmodule

// File: tb/tb_hall_conditioner.sv
// Bench for hall_conditioner: directed scenarios plus randomized hall activity,
// every cycle compared against a behavioural model of the hall rules.
module tb_hall_conditioner;

    localparam int D     = 16;
    localparam int STALL = 1000;
    localparam int W     = 12;
    localparam int MAXC  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   hall_raw = 3'b000;
    logic         enable = 1'b0;
    logic         clear_fault = 1'b0;
    logic [2:0]   hall_signal;
    logic         hall_valid;
    logic         fault;
    logic [1:0]   fault_code;
    logic [W-1:0] period;
    logic         period_valid;

    hall_conditioner #(.DEBOUNCE_CYCLES(D), .STALL_CYCLES(STALL), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .hall_raw(hall_raw), .enable(enable),
        .clear_fault(clear_fault), .hall_signal(hall_signal), .hall_valid(hall_valid),
        .fault(fault), .fault_code(fault_code), .period(period), .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pv_seen  = 0;
    bit chk_on   = 1'b0;
    int seq[6]   = '{1, 3, 2, 6, 4, 5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int m_stable, m_from, m_code, m_pcnt, m_period, m_hs;
    bit m_chg, m_fault, m_armed, m_pv, m_hv;
    int last_raw, run, pend_due, pend_val, edge_n;
    bit pend;

    function automatic bit legal(input int c);
        return c >= 1 && c <= 6;
    endfunction

    function automatic int pos(input int c);
        for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step();
        bit inv, stepped, adj, skip, ltr, stall, raise, clr;
        int ncode, d;
        edge_n++;
        if (reset) begin
            m_stable = 0; m_from = 0; m_chg = 0; m_fault = 0; m_code = 0;
            m_pcnt = 0; m_armed = 0; m_period = 0; m_pv = 0; m_hs = 0; m_hv = 0;
            last_raw = 0; run = D + 2; pend = 0;
        end else begin
            inv     = !legal(m_stable);
            stepped = m_chg && legal(m_from) && legal(m_stable);
            d       = (pos(m_stable) - pos(m_from) + 6) % 6;
            adj     = (d == 1) || (d == 5);
            skip    = stepped && !adj;
            ltr     = stepped && adj;
            stall   = (m_pcnt == STALL - 1);
            raise   = enable && (inv || skip || stall);
            ncode   = inv ? 1 : (skip ? 2 : 3);
            clr     = m_fault && clear_fault && legal(m_stable) && !raise;
            m_pv    = 0;
            if (raise && (!m_fault || (clear_fault && legal(m_stable)))) begin
                m_fault = 1; m_code = ncode;
            end else if (clr) begin
                m_fault = 0; m_code = 0;
            end
            if (!enable || clr) begin
                m_pcnt = 0; m_armed = 0;
            end else if (ltr) begin
                if (m_armed) begin
                    m_period = (m_pcnt + 1 > MAXC) ? MAXC : m_pcnt + 1;
                    m_pv = 1;
                end
                m_pcnt = 0; m_armed = 1;
            end else if (m_pcnt < MAXC) begin
                m_pcnt++;
            end
            // A code held for D+1 consecutive samples becomes stable two edges later.
            if (pend && pend_due == edge_n) begin
                m_chg = 1; m_from = m_stable; m_stable = pend_val; pend = 0;
            end else begin
                m_chg = 0;
            end
            m_hv = !m_fault && legal(m_stable);
            m_hs = m_hv ? m_stable : 0;
            if (int'(hall_raw) == last_raw) begin
                if (run < D + 2) run++;
            end else begin
                last_raw = int'(hall_raw); run = 1;
            end
            if (run == D + 1 && last_raw != m_stable) begin
                pend = 1; pend_due = edge_n + 2; pend_val = last_raw;
            end
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {12'd0, hall_signal, hall_valid, fault, fault_code, period_valid, period};
    endfunction

    function automatic logic [31:0] model_vec();
        return {12'd0, 3'(m_hs), m_hv, m_fault, 2'(m_code), m_pv, 12'(m_period)};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("cycle", dut_vec(), model_vec());
            if (period_valid === 1'b1) pv_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input int code, input int n);
        hall_raw = 3'(code);
        cyc(n);
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        cyc(1);
        clear_fault = 1'b0;
    endtask

    initial begin
        int pvs, cur, kind, len, g;
        reset = 1'b1;
        cyc(2);
        chk_on = 1'b1;
        check("reset_outs", dut_vec(), 32'd0);
        reset = 1'b0;

        // Forward rotation, 100 cycles per code
        hold(1, 30);
        enable = 1'b1;
        pvs = pv_seen;
        for (int i = 1; i <= 12; i++) begin
            if (i == 1) begin
                hall_raw = 3'b011;
                cyc(18);
                check("lat_before", 32'(hall_signal), 32'd1);
                cyc(1);
                check("lat_after", 32'(hall_signal), 32'd3);
                cyc(81);
            end else begin
                hold(seq[i % 6], 100);
            end
        end
        hold(seq[0], 30);
        check("rot_strobes", 32'(pv_seen - pvs), 32'd11);
        check("rot_period", 32'(period), 32'd100);
        check("rot_nofault", 32'(fault), 32'd0);

        // Short glitch is rejected
        hold(3, 30);
        hold(7, 5);
        hold(3, 30);
        check("glitch_hold", 32'(hall_signal), 32'd3);
        check("glitch_nofault", 32'(fault), 32'd0);

        // Invalid code, then recover and clear
        hold(7, 30);
        check("inv_code", {29'd0, fault, fault_code}, 32'd5);
        check("inv_hs", 32'(hall_signal), 32'd0);
        hold(1, 25);
        pulse_clear();
        check("inv_clear", {29'd0, fault, hall_valid, 1'b0}, 32'd2);

        // Skip with enable, then the same kind of skip without
        hold(2, 25);
        check("skip_code", {29'd0, fault, fault_code}, 32'd6);
        pulse_clear();
        check("skip_clear", 32'(fault), 32'd0);
        enable = 1'b0;
        hold(4, 25);
        check("skip_disabled", 32'(fault), 32'd0);

        // Stall fault exactly STALL cycles after the last transition is processed
        enable = 1'b1;
        hall_raw = 3'b101;
        cyc(1019);
        check("stall_before", 32'(fault), 32'd0);
        cyc(1);
        check("stall_at", {29'd0, fault, fault_code}, 32'd7);
        pulse_clear();
        check("stall_clear", 32'(fault), 32'd0);

        // Reverse rotation
        pvs = pv_seen;
        for (int i = 4; i >= 0; i--) hold(seq[i], 60);
        check("rev_strobes", 32'(pv_seen - pvs), 32'd4);
        check("rev_period", 32'(period), 32'd60);

        // Randomized activity
        cur = 0;
        for (int it = 0; it < 70; it++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 150));
            if ($urandom_range(0, 14) == 0) len = 1100;
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if (kind <= 2) begin
                cur = (cur + 1) % 6; hold(seq[cur], len);
            end else if (kind <= 5) begin
                cur = (cur + 5) % 6; hold(seq[cur], len);
            end else if (kind == 6) begin
                cur = (cur + 2 + int'($urandom_range(0, 1))) % 6; hold(seq[cur], len);
            end else if (kind == 7) begin
                hold(($urandom_range(0, 1) != 0) ? 7 : 0, len);
            end else if (kind == 8) begin
                g = int'($urandom_range(0, 7));
                hold(g, int'($urandom_range(1, D)));
                hold(seq[cur], len);
            end else begin
                hold(seq[cur], len);
            end
            if ($urandom_range(0, 2) == 0) pulse_clear();
        end

        // Reset with a fault latched, then re-arm
        enable = 1'b1;
        hold(7, 30);
        check("pre_rst_fault", 32'(fault), 32'd1);
        reset = 1'b1;
        enable = 1'b0;
        cyc(1);
        check("rst_outs", dut_vec(), 32'd0);
        reset = 1'b0;
        hold(1, 30);
        enable = 1'b1;
        pvs = pv_seen;
        hold(3, 100);
        check("rst_first_arm", 32'(pv_seen - pvs), 32'd0);
        hold(2, 40);
        check("rst_second", 32'(pv_seen - pvs), 32'd1);
        check("rst_period", 32'(period), 32'd100);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
